trig_route_shaper: RTL and testbench
====================================

Name: trig_route_shaper

Overview:
Parametrised successor to the top-level trigger mux. The top-level mux chooses between the M3 GPIO trigger and the trace-match trigger. This block selects one of pNUM_SRC synchronous trigger sources and shapes the result into trig_out. Modes are passthrough, delayed fixed-width pulse, and armed one-shot. It also provides a saturating trigger counter and an LED activity stretcher, and sits between trace_top/M3 trigger sources and the trig_out pin.

Parameters:
pNUM_SRC, 4, number of trigger sources (>=2)
pSEL_WIDTH, 2, width of source select; must satisfy 2^pSEL_WIDTH >= pNUM_SRC
pDELAY_WIDTH, 16, width of delay count
pWIDTH_WIDTH, 16, width of pulse-width count
pCOUNT_WIDTH, 16, width of trigger counter
pLED_STRETCH, 22, LED stretch length is 2^pLED_STRETCH cycles

Ports:
trace_clk_in  in  1  sole clock; all inputs synchronous to it
resetn  in  1  asynchronous, active-low reset
I_trig_src  in  pNUM_SRC  trigger sources (level)
I_src_sel  in  pSEL_WIDTH  source index; values >= pNUM_SRC select constant 0
I_mode  in  2  0=PASS, 1=PULSE, 2=ONESHOT, 3=reserved (output held 0)
I_delay  in  pDELAY_WIDTH  cycles from edge to pulse start
I_width  in  pWIDTH_WIDTH  pulse width in cycles; 0 treated as 1
I_arm  in  1  single-cycle arm strobe (ONESHOT)
I_count_clr  in  1  synchronous clear of trigger counter
O_trig_out  out  1  shaped trigger
O_armed  out  1  ONESHOT armed flag
O_busy  out  1  FSM in DELAY or PULSE
O_trig_count  out  pCOUNT_WIDTH  accepted-trigger count, saturating
O_activity  out  1  LED stretcher output

Behaviour:
- Reset: every output 0; FSM=IDLE; all counters 0; edge-detect register 0.
- Source selection:
  - sel = I_trig_src[I_src_sel], registered into src_q.
  - Rising edge = src_q & ~src_prev.
  - On a change of I_src_sel, src_prev is loaded with the new src_q value in the next cycle, so the switch itself produces no false edge.
- PASS mode:
  - O_trig_out = src_q, giving 1-cycle latency from I_trig_src.
  - FSM stays IDLE; each rising edge is an accepted trigger.
- PULSE mode:
  - FSM states are IDLE, DELAY, PULSE, DONE.
  - IDLE + edge: latch I_delay into dcnt and max(I_width,1) into wcnt. Go to DELAY if delay != 0, else PULSE.
  - DELAY: decrement dcnt each cycle; at 1 → PULSE.
  - PULSE: O_trig_out=1; decrement wcnt; at 1 → IDLE (PULSE mode) or DONE (ONESHOT mode).
  - Timing: if the source is first sampled into src_q at cycle k, O_trig_out is high from cycle k+1+D for exactly W cycles.
  - Edges arriving during DELAY/PULSE are ignored and not counted. I_delay/I_width changes during a pulse have no effect until the next trigger.
- ONESHOT mode:
  - I_arm sets O_armed.
  - An edge is accepted only if O_armed. Acceptance clears O_armed and runs DELAY/PULSE as above, ending in DONE.
  - DONE: output 0. I_arm → IDLE with O_armed=1.
  - I_arm while busy: O_armed set, takes effect for the next edge after the FSM returns via DONE.
  - I_arm and an accepted edge in the same cycle: the edge is accepted and O_armed ends at 0.
- Mode change: any change of I_mode forces FSM to IDLE, O_trig_out=0 and O_armed=0 on the next clock. Any in-progress pulse is truncated.
- Reserved mode 3: O_trig_out=0; no triggers are accepted.
- O_busy = (state==DELAY || state==PULSE).
- Trigger counter:
  - +1 per accepted trigger; saturates at all-ones with no wrap.
  - I_count_clr has priority over a simultaneous increment; the result is 0.
- Activity stretcher:
  - A rising edge of O_trig_out loads the counter with 2^pLED_STRETCH-1 and sets O_activity.
  - O_activity drops when the counter reaches 0.
  - A re-trigger restarts the count.
- resetn asserted mid-operation: immediate return to reset state, asynchronously.

Test Plan:
- Reset during a PULSE: drive resetn=0 → O_trig_out, O_busy, O_armed, O_trig_count all 0 asynchronously, before the next clock edge.
- PASS, sel=1: I_trig_src[1] high for 5 cycles → O_trig_out high 5 cycles, 1 cycle late; count=1. Then sel=3 with src[3] already high → no count increment.
- PULSE, D=3, W=4: src edge sampled at k → O_trig_out high for cycles k+4..k+7, O_busy high k+1..k+7. A second edge at k+2 is ignored; count=1. With D=0, W=0 → 1-cycle pulse at k+1.
- ONESHOT: two edges with no arm → no output. I_arm, then 2 edges → exactly one pulse; O_armed=0 afterwards; count=1. Re-arm → next edge fires again.
- Counter: pCOUNT_WIDTH=4, 17 triggers → count=15. I_count_clr coincident with a trigger → count=0.
- Mode switch PULSE→PASS midway through a W=100 pulse → O_trig_out follows src_q from the next cycle; O_busy=0.

Source files
------------

// File: rtl/trig_route_shaper.sv
// trig_route_shaper
//   Selects one of pNUM_SRC synchronous trigger sources and shapes it onto
//   the trigger output pin. Three shaping modes: passthrough, delayed
//   fixed-width pulse, and armed one-shot. Also keeps a saturating count of
//   accepted triggers and drives an LED activity stretcher.
//
// Ports
//   trace_clk_in  : sole clock
//   resetn        : asynchronous active-low reset
//   I_trig_src    : trigger source levels
//   I_src_sel     : source index (out-of-range index selects constant 0)
//   I_mode        : 0=PASS, 1=PULSE, 2=ONESHOT, 3=reserved (output held 0)
//   I_delay       : cycles from accepted edge to pulse start
//   I_width       : pulse width in cycles (0 behaves as 1)
//   I_arm         : one-shot arm strobe
//   I_count_clr   : synchronous clear of the trigger counter
//   O_trig_out    : shaped trigger
//   O_armed       : one-shot armed flag
//   O_busy        : high while in DELAY or PULSE
//   O_trig_count  : saturating accepted-trigger count
//   O_activity    : stretched LED activity indication
//
// FSM states
//   state | meaning
//   IDLE  | waiting for an accepted rising edge
//   DELAY | counting down I_delay before the pulse
//   PULSE | output high, counting down the pulse width
//   DONE  | one-shot fired; waits for a re-arm before returning to IDLE

module trig_route_shaper #(
  parameter int pNUM_SRC     = 4,
  parameter int pSEL_WIDTH   = 2,
  parameter int pDELAY_WIDTH = 16,
  parameter int pWIDTH_WIDTH = 16,
  parameter int pCOUNT_WIDTH = 16,
  parameter int pLED_STRETCH = 22
) (
  input  logic                    trace_clk_in,
  input  logic                    resetn,
  input  logic [pNUM_SRC-1:0]     I_trig_src,
  input  logic [pSEL_WIDTH-1:0]   I_src_sel,
  input  logic [1:0]              I_mode,
  input  logic [pDELAY_WIDTH-1:0] I_delay,
  input  logic [pWIDTH_WIDTH-1:0] I_width,
  input  logic                    I_arm,
  input  logic                    I_count_clr,
  output logic                    O_trig_out,
  output logic                    O_armed,
  output logic                    O_busy,
  output logic [pCOUNT_WIDTH-1:0] O_trig_count,
  output logic                    O_activity
);

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_PULSE   = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_PULSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [pDELAY_WIDTH-1:0] DCNT_ONE = {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pWIDTH_WIDTH-1:0] WCNT_ONE = {{(pWIDTH_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pCOUNT_WIDTH-1:0] CNT_ONE  = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pLED_STRETCH-1:0] LED_ONE  = {{(pLED_STRETCH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic                    src_q, src_d;
  logic                    src_prev_q;
  logic [pSEL_WIDTH-1:0]   sel_q;
  logic                    sel_chg_q, sel_chg_d;
  logic [1:0]              mode_q;
  logic [1:0]              state_q, state_d;
  logic [pDELAY_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [pWIDTH_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                    armed_q, armed_d;
  logic [pCOUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    trig_prev_q;
  logic [pLED_STRETCH-1:0] led_cnt_q, led_cnt_d;
  logic                    act_q, act_d;

  // ---------------------------------------------------------------------
  // Source selection and edge detection
  // ---------------------------------------------------------------------
  always_comb begin
    src_d = 1'b0;
    for (int i = 0; i < pNUM_SRC; i++) begin
      if (int'(I_src_sel) == i) src_d = I_trig_src[i];
    end
  end

  assign sel_chg_d = (I_src_sel != sel_q);

  // sel_chg_q is high in the first cycle src_q carries the newly selected
  // source; masking the edge there stops a source switch from looking like
  // a trigger. src_prev_q catches up with the new source one cycle later.
  logic rise;
  assign rise = src_q & ~src_prev_q & ~sel_chg_q;

  // ---------------------------------------------------------------------
  // Mode handling and trigger acceptance
  // ---------------------------------------------------------------------
  logic mode_chg;
  logic fsm_mode;
  logic accept;
  logic [pWIDTH_WIDTH-1:0] width_eff;

  assign mode_chg  = (I_mode != mode_q);
  assign fsm_mode  = (mode_q == MODE_PULSE) || (mode_q == MODE_ONESHOT);
  assign width_eff = (I_width == '0) ? WCNT_ONE : I_width;

  // The cycle in which the mode register updates accepts nothing; the FSM
  // is being forced back to IDLE at that edge.
  always_comb begin
    accept = 1'b0;
    if (!mode_chg && rise) begin
      if (mode_q == MODE_PASS) begin
        accept = 1'b1;
      end else if (mode_q == MODE_PULSE) begin
        accept = (state_q == ST_IDLE);
      end else if (mode_q == MODE_ONESHOT) begin
        accept = (state_q == ST_IDLE) && armed_q;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pulse FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    armed_d = armed_q;
    if (mode_chg) begin
      state_d = ST_IDLE;
      armed_d = 1'b0;
    end else begin
      if ((mode_q == MODE_ONESHOT) && I_arm) armed_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept && fsm_mode) begin
            dcnt_d  = I_delay;
            wcnt_d  = width_eff;
            state_d = (I_delay != '0) ? ST_DELAY : ST_PULSE;
            // Acceptance wins over a coincident arm strobe.
            if (mode_q == MODE_ONESHOT) armed_d = 1'b0;
          end
        end
        ST_DELAY: begin
          dcnt_d = dcnt_q - DCNT_ONE;
          if (dcnt_q == DCNT_ONE) state_d = ST_PULSE;
        end
        ST_PULSE: begin
          wcnt_d = wcnt_q - WCNT_ONE;
          if (wcnt_q == WCNT_ONE) begin
            state_d = (mode_q == MODE_ONESHOT) ? ST_DONE : ST_IDLE;
          end
        end
        ST_DONE: begin
          // An arm that arrived while busy is already held in armed_q.
          if (I_arm || armed_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Trigger counter
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (I_count_clr) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != {pCOUNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------
  // Output shaping
  // ---------------------------------------------------------------------
  logic trig_out;
  always_comb begin
    trig_out = 1'b0;
    if (mode_q == MODE_PASS) begin
      trig_out = src_q;
    end else if (fsm_mode) begin
      trig_out = (state_q == ST_PULSE);
    end
  end

  // ---------------------------------------------------------------------
  // LED activity stretcher
  // ---------------------------------------------------------------------
  logic trig_rise;
  assign trig_rise = trig_out & ~trig_prev_q;

  always_comb begin
    led_cnt_d = led_cnt_q;
    act_d     = act_q;
    if (trig_rise) begin
      led_cnt_d = {pLED_STRETCH{1'b1}};
      act_d     = 1'b1;
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - LED_ONE;
    end else begin
      act_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge trace_clk_in or negedge resetn) begin
    if (!resetn) begin
      src_q       <= 1'b0;
      src_prev_q  <= 1'b0;
      sel_q       <= '0;
      sel_chg_q   <= 1'b0;
      mode_q      <= MODE_PASS;
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      trig_prev_q <= 1'b0;
      led_cnt_q   <= '0;
      act_q       <= 1'b0;
    end else begin
      src_q       <= src_d;
      src_prev_q  <= src_q;
      sel_q       <= I_src_sel;
      sel_chg_q   <= sel_chg_d;
      mode_q      <= I_mode;
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      trig_prev_q <= trig_out;
      led_cnt_q   <= led_cnt_d;
      act_q       <= act_d;
    end
  end

  assign O_trig_out   = trig_out;
  assign O_armed      = armed_q;
  assign O_busy       = (state_q == ST_DELAY) || (state_q == ST_PULSE);
  assign O_trig_count = cnt_q;
  assign O_activity   = act_q;

endmodule

// File: tb/tb_trig_route_shaper.sv
// tb_trig_route_shaper
//   Directed bench for trig_route_shaper with a 4-bit counter and a short
//   LED stretch (2^3 cycles). Inputs change 1 time unit after the rising
//   clock edge and outputs are sampled at the same point.

module tb_trig_route_shaper;

  localparam int NS = 4;
  localparam int SW = 2;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int CW = 4;
  localparam int LS = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NS-1:0] I_trig_src;
  logic [SW-1:0] I_src_sel;
  logic [1:0]    I_mode;
  logic [DW-1:0] I_delay;
  logic [WW-1:0] I_width;
  logic          I_arm;
  logic          I_count_clr;
  logic          O_trig_out;
  logic          O_armed;
  logic          O_busy;
  logic [CW-1:0] O_trig_count;
  logic          O_activity;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  trig_route_shaper #(
    .pNUM_SRC    (NS),
    .pSEL_WIDTH  (SW),
    .pDELAY_WIDTH(DW),
    .pWIDTH_WIDTH(WW),
    .pCOUNT_WIDTH(CW),
    .pLED_STRETCH(LS)
  ) dut (
    .trace_clk_in(clk),
    .resetn      (rstn),
    .I_trig_src  (I_trig_src),
    .I_src_sel   (I_src_sel),
    .I_mode      (I_mode),
    .I_delay     (I_delay),
    .I_width     (I_width),
    .I_arm       (I_arm),
    .I_count_clr (I_count_clr),
    .O_trig_out  (O_trig_out),
    .O_armed     (O_armed),
    .O_busy      (O_busy),
    .O_trig_count(O_trig_count),
    .O_activity  (O_activity)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_count();
    I_count_clr = 1'b1;
    tick();
    I_count_clr = 1'b0;
  endtask

  // One-cycle source pulse followed by five low cycles; returns how many of
  // the six sampled cycles had O_trig_out high.
  task automatic src_pulse(input int idx, output int highs);
    highs = 0;
    I_trig_src[idx] = 1'b1;
    tick();
    highs += int'(O_trig_out);
    I_trig_src[idx] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      highs += int'(O_trig_out);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    n_checks++;
    if ({O_trig_out, O_armed, O_busy, O_trig_count, O_activity} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0",
               {O_trig_out, O_armed, O_busy, O_trig_count, O_activity});
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_pass_select();
    logic [7:0] v;
    I_mode = 2'd0;
    I_src_sel = 2'd1;
    I_trig_src = '0;
    tick();
    tick();
    clear_count();
    v = '0;
    for (int i = 0; i < 8; i++) begin
      I_trig_src[1] = (i < 5);
      if (i == 0) begin
        #1;
        n_checks++;
        if (O_trig_out !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_latency: got %b required 0 before clock", O_trig_out);
        end
      end
      tick();
      v[i] = O_trig_out;
    end
    n_checks++;
    if (v !== 8'b0001_1111) begin
      n_fail++;
      $display("FAIL pass_shape: got %b required 00011111", v);
    end
    n_checks++;
    if (O_trig_count !== 4'd1) begin
      n_fail++;
      $display("FAIL pass_count: got %0d required 1", O_trig_count);
    end
    I_trig_src[3] = 1'b1;
    tick();
    tick();
    I_src_sel = 2'd3;
    tick();
    tick();
    tick();
    n_checks++;
    if (O_trig_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sel_switch_out: got %b required 1", O_trig_out);
    end
    n_checks++;
    if (O_trig_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sel_switch_no_edge: got %0d required 1", O_trig_count);
    end
    I_trig_src = '0;
    I_src_sel = 2'd0;
    tick();
    tick();
  endtask

  task automatic test_pulse_delay();
    logic [9:0] tv;
    logic [9:0] bv;
    I_mode = 2'd1;
    I_src_sel = 2'd0;
    I_trig_src = '0;
    I_delay = 16'd3;
    I_width = 16'd4;
    tick();
    tick();
    clear_count();
    I_trig_src[0] = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tv[i] = O_trig_out;
      bv[i] = O_busy;
      if (i == 0) I_trig_src[0] = 1'b0;
      if (i == 1) I_trig_src[0] = 1'b1;
      if (i == 2) begin
        I_delay = 16'd0;
        I_width = 16'd1;
      end
      tick();
    end
    n_checks++;
    if (tv !== 10'b00_1111_0000) begin
      n_fail++;
      $display("FAIL pulse_d3w4_out: got %b required 0011110000", tv);
    end
    n_checks++;
    if (bv !== 10'b00_1111_1110) begin
      n_fail++;
      $display("FAIL pulse_d3w4_busy: got %b required 0011111110", bv);
    end
    n_checks++;
    if (O_trig_count !== 4'd1) begin
      n_fail++;
      $display("FAIL pulse_d3w4_count: got %0d required 1", O_trig_count);
    end
    I_trig_src = '0;
    tick();
    tick();
  endtask

  task automatic test_pulse_min();
    I_mode = 2'd1;
    I_delay = 16'd0;
    I_width = 16'd0;
    I_trig_src = '0;
    clear_count();
    tick();
    I_trig_src[0] = 1'b1;
    tick();
    n_checks++;
    if (O_trig_out !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_min_k: got %b required 0", O_trig_out);
    end
    tick();
    n_checks++;
    if ({O_trig_out, O_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL pulse_min_k1: got %b required 11", {O_trig_out, O_busy});
    end
    tick();
    n_checks++;
    if ({O_trig_out, O_busy, O_activity} !== 3'b001) begin
      n_fail++;
      $display("FAIL pulse_min_k2: got %b required 001", {O_trig_out, O_busy, O_activity});
    end
    I_trig_src = '0;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (O_activity !== 1'b0) begin
      n_fail++;
      $display("FAIL activity_decay: got %b required 0", O_activity);
    end
    n_checks++;
    if (O_trig_count !== 4'd1) begin
      n_fail++;
      $display("FAIL pulse_min_count: got %0d required 1", O_trig_count);
    end
  endtask

  task automatic test_oneshot();
    int h1;
    int h2;
    I_mode = 2'd2;
    I_delay = 16'd0;
    I_width = 16'd2;
    I_trig_src = '0;
    tick();
    tick();
    clear_count();
    src_pulse(0, h1);
    src_pulse(0, h2);
    n_checks++;
    if ({h1 + h2, 32'(O_trig_count), 32'(O_armed)} !== {32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL oneshot_unarmed: highs %0d count %0d armed %b required 0 0 0",
               h1 + h2, O_trig_count, O_armed);
    end
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
    n_checks++;
    if (O_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_arm: got %b required 1", O_armed);
    end
    src_pulse(0, h1);
    src_pulse(0, h2);
    n_checks++;
    if (h1 + h2 !== 2) begin
      n_fail++;
      $display("FAIL oneshot_single_pulse: got %0d high cycles required 2", h1 + h2);
    end
    n_checks++;
    if ({O_armed, O_trig_count} !== {1'b0, 4'd1}) begin
      n_fail++;
      $display("FAIL oneshot_after: armed %b count %0d required 0 1", O_armed, O_trig_count);
    end
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
    n_checks++;
    if (O_armed !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_rearm: got %b required 1", O_armed);
    end
    src_pulse(0, h1);
    n_checks++;
    if ({h1, 32'(O_trig_count)} !== {32'd2, 32'd2}) begin
      n_fail++;
      $display("FAIL oneshot_refire: highs %0d count %0d required 2 2", h1, O_trig_count);
    end
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
    I_trig_src[0] = 1'b1;
    tick();
    I_arm = 1'b1;
    tick();
    I_arm = 1'b0;
    n_checks++;
    if ({O_armed, O_trig_count} !== {1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL oneshot_arm_and_edge: armed %b count %0d required 0 3", O_armed, O_trig_count);
    end
    I_trig_src = '0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_counter_sat();
    int h;
    I_mode = 2'd0;
    I_src_sel = 2'd0;
    I_trig_src = '0;
    tick();
    tick();
    clear_count();
    for (int i = 0; i < 17; i++) src_pulse(0, h);
    n_checks++;
    if (O_trig_count !== 4'd15) begin
      n_fail++;
      $display("FAIL count_saturate: got %0d required 15", O_trig_count);
    end
  endtask

  task automatic test_count_clr();
    I_mode = 2'd0;
    clear_count();
    I_trig_src[0] = 1'b1;
    tick();
    I_trig_src[0] = 1'b0;
    tick();
    n_checks++;
    if (O_trig_count !== 4'd1) begin
      n_fail++;
      $display("FAIL count_one: got %0d required 1", O_trig_count);
    end
    I_trig_src[0] = 1'b1;
    tick();
    I_count_clr = 1'b1;
    tick();
    I_count_clr = 1'b0;
    I_trig_src[0] = 1'b0;
    tick();
    tick();
    n_checks++;
    if (O_trig_count !== 4'd0) begin
      n_fail++;
      $display("FAIL count_clr_priority: got %0d required 0", O_trig_count);
    end
  endtask

  task automatic test_mode_switch();
    I_mode = 2'd1;
    I_delay = 16'd0;
    I_width = 16'd100;
    I_trig_src = '0;
    tick();
    tick();
    I_trig_src[0] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({O_trig_out, O_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL long_pulse_active: got %b required 11", {O_trig_out, O_busy});
    end
    I_mode = 2'd0;
    I_trig_src[0] = 1'b0;
    tick();
    n_checks++;
    if ({O_trig_out, O_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL mode_switch_truncate: got %b required 00", {O_trig_out, O_busy});
    end
    I_trig_src[0] = 1'b1;
    tick();
    n_checks++;
    if ({O_trig_out, O_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL mode_switch_follow: got %b required 10", {O_trig_out, O_busy});
    end
    I_trig_src = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_midpulse();
    I_mode = 2'd1;
    I_delay = 16'd0;
    I_width = 16'd100;
    tick();
    tick();
    I_trig_src[0] = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if ({O_trig_out, O_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %b required 11", {O_trig_out, O_busy});
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({O_trig_out, O_armed, O_busy, O_trig_count} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b required 0",
               {O_trig_out, O_armed, O_busy, O_trig_count});
    end
    I_trig_src = '0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn        = 1'b0;
    I_trig_src  = '0;
    I_src_sel   = '0;
    I_mode      = 2'd0;
    I_delay     = '0;
    I_width     = '0;
    I_arm       = 1'b0;
    I_count_clr = 1'b0;
    test_reset();
    test_pass_select();
    test_pulse_delay();
    test_pulse_min();
    test_oneshot();
    test_counter_sat();
    test_count_clr();
    test_mode_switch();
    test_reset_midpulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
